// File: rtl/mp_issue_ctrl.sv
// mp_issue_ctrl: issue controller in front of the datapath instruction input.
// Buffers producer instructions in a small FIFO, discards invalid opcodes,
// holds back the head while a source register is still being written by a
// recently issued instruction, and registers at most one issue per cycle.
// Optional build macro: MP_ISSUE_STATS_EN adds saturating issue/drop/stall
// counters (stat_issued, stat_dropped, stat_stalls).
module mp_issue_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int HAZ_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   output logic        in_ready,
   input  logic        flush,
   output logic        issue_valid,
   output logic [31:0] issue_instr,
   output logic        drop_pulse,
   output logic        busy,
   output logic [1:0]  state
`ifdef MP_ISSUE_STATS_EN
   ,
   output logic [15:0] stat_issued,
   output logic [15:0] stat_dropped,
   output logic [15:0] stat_stalls
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   // FIFO storage and bookkeeping
   logic [31:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;

   // Hazard window: entry 0 is the newest issue
   logic [HAZ_DEPTH-1:0] win_valid_reg;
   logic [4:0]           win_addr_reg [HAZ_DEPTH];

   // Output and FSM registers
   logic        issue_valid_reg;
   logic [31:0] issue_instr_reg;
   logic        drop_reg;
   logic [1:0]  state_reg;
   logic [1:0]  state_next;

   // Head decode
   logic [31:0] head;
   logic [5:0]  head_op;
   logic [4:0]  head_a1;
   logic [4:0]  head_a2;
   logic [4:0]  head_dst;
   logic        op_valid;
   logic        op_unary;

   // Per-cycle decisions
   logic full;
   logic empty;
   logic in_flush;
   logic flush_now;
   logic head_live;
   logic drop_now;
   logic stall_now;
   logic issue_now;
   logic push;
   logic pop;
   logic hit;
   logic hit_next;
   logic [HAZ_DEPTH-1:0] match;
   logic [HAZ_DEPTH-1:0] match_keep;

   // The FIFO is tiny, so the head is read combinationally for evaluation.
   assign head     = mem[rd_ptr_reg];
   assign head_op  = head[5:0];
   assign head_a1  = head[10:6];
   assign head_a2  = head[15:11];
   assign head_dst = head[20:16];

   // Opcode classification: which opcodes exist and which read addr1 only
   always_comb begin
      op_valid = 1'b0;
      op_unary = 1'b0;
      case (head_op)
         6'd2, 6'd7, 6'd13: begin
            op_valid = 1'b1;
            op_unary = 1'b1;
         end
         6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd10, 6'd12, 6'd15: begin
            op_valid = 1'b1;
         end
         default: begin
            op_valid = 1'b0;
         end
      endcase
   end

   // RAW compare against every window entry. match_keep excludes the oldest
   // entry, which is exactly the set that will still be live next cycle if
   // the head stalls now (a stall inserts nothing into the window).
   genvar gi;
   generate
      for (gi = 0; gi < HAZ_DEPTH; gi++) begin : g_haz
         assign match[gi] = win_valid_reg[gi] &&
                            ((win_addr_reg[gi] == head_a1) ||
                             (!op_unary && (win_addr_reg[gi] == head_a2)));
         if (gi < HAZ_DEPTH - 1) begin : g_keep
            assign match_keep[gi] = match[gi];
         end else begin : g_oldest
            assign match_keep[gi] = 1'b0;
         end
      end
   endgenerate

   assign hit      = |match;
   assign hit_next = |match_keep;

   assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
   assign empty     = (count_reg == '0);
   assign in_flush  = (state_reg == S_FLUSH);
   assign flush_now = flush && !in_flush;
   assign in_ready  = !full && !in_flush;

   assign head_live = !empty && !flush_now;
   assign drop_now  = head_live && !op_valid;
   assign stall_now = head_live && op_valid && hit;
   assign issue_now = head_live && op_valid && !hit;
   assign pop       = drop_now || issue_now;
   assign push      = in_valid && in_ready && !flush_now;

   // Occupancy after this cycle; flush wins over any push or pop
   always_comb begin
      count_next = count_reg;
      if (flush_now) begin
         count_next = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   // Next state. STALL is entered only when the head is certain to remain
   // blocked next cycle too, so it marks cycles of a sustained stall.
   always_comb begin
      state_next = state_reg;
      if (in_flush) begin
         if (!(|win_valid_reg)) begin
            state_next = S_IDLE;
         end
      end else if (flush_now) begin
         state_next = S_FLUSH;
      end else if (stall_now && hit_next) begin
         state_next = S_STALL;
      end else if (count_next != '0) begin
         state_next = S_ISSUE;
      end else begin
         state_next = S_IDLE;
      end
   end

   // FIFO data write; storage needs no reset because count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= in_instr;
      end
   end

   // FIFO pointers and count; pointers wrap naturally at a power-of-two depth
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         count_reg <= count_next;
         if (flush_now) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) begin
               wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
         end
      end
   end

   // Hazard window shifts every cycle; only an issue inserts a valid entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid_reg <= '0;
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            win_addr_reg[i] <= '0;
         end
      end else begin
         win_valid_reg[0] <= issue_now;
         win_addr_reg[0]  <= head_dst;
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            win_valid_reg[i] <= win_valid_reg[i-1];
            win_addr_reg[i]  <= win_addr_reg[i-1];
         end
      end
   end

   // Registered issue/drop outputs; issue_instr holds between issues
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_valid_reg <= 1'b0;
         issue_instr_reg <= '0;
         drop_reg        <= 1'b0;
      end else begin
         issue_valid_reg <= issue_now;
         drop_reg        <= drop_now;
         if (issue_now) begin
            issue_instr_reg <= head;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   assign issue_valid = issue_valid_reg;
   assign issue_instr = issue_instr_reg;
   assign drop_pulse  = drop_reg;
   assign state       = state_reg;
   assign busy        = !empty || (|win_valid_reg) || in_flush;

`ifdef MP_ISSUE_STATS_EN
   logic [15:0] stat_issued_reg;
   logic [15:0] stat_dropped_reg;
   logic [15:0] stat_stalls_reg;

   // Saturating event counters; cleared only by reset, never by flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issued_reg  <= '0;
         stat_dropped_reg <= '0;
         stat_stalls_reg  <= '0;
      end else begin
         if (issue_now && (stat_issued_reg != 16'hFFFF)) begin
            stat_issued_reg <= stat_issued_reg + 16'd1;
         end
         if (drop_now && (stat_dropped_reg != 16'hFFFF)) begin
            stat_dropped_reg <= stat_dropped_reg + 16'd1;
         end
         if ((state_reg == S_STALL) && (stat_stalls_reg != 16'hFFFF)) begin
            stat_stalls_reg <= stat_stalls_reg + 16'd1;
         end
      end
   end

   assign stat_issued  = stat_issued_reg;
   assign stat_dropped = stat_dropped_reg;
   assign stat_stalls  = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_mp_issue_ctrl.sv
// tb_mp_issue_ctrl: directed self-checking bench for mp_issue_ctrl at default
// parameters (FIFO_DEPTH=4, HAZ_DEPTH=2). Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_mp_issue_ctrl;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;
   localparam logic [1:0] S_FLUSH = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic        flush = 1'b0;
   logic        in_ready;
   logic        issue_valid;
   logic [31:0] issue_instr;
   logic        drop_pulse;
   logic        busy;
   logic [1:0]  state;
`ifdef MP_ISSUE_STATS_EN
   logic [15:0] stat_issued;
   logic [15:0] stat_dropped;
   logic [15:0] stat_stalls;
   logic [15:0] base_a;
   logic [15:0] base_b;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   mp_issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_instr    (in_instr),
      .in_ready    (in_ready),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_instr (issue_instr),
      .drop_pulse  (drop_pulse),
      .busy        (busy),
      .state       (state)
`ifdef MP_ISSUE_STATS_EN
      ,
      .stat_issued (stat_issued),
      .stat_dropped(stat_dropped),
      .stat_stalls (stat_stalls)
`endif
   );

   always #5 clk = ~clk;

   // One comparison: count it, report a mismatch
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%08h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic go_idle(input int n);
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (n) step();
   endtask

   task automatic check_reset_values(input string pfx);
      check_eq({pfx, "_issue_valid"}, {31'd0, issue_valid}, 32'd0);
      check_eq({pfx, "_issue_instr"}, issue_instr, 32'd0);
      check_eq({pfx, "_drop_pulse"},  {31'd0, drop_pulse}, 32'd0);
      check_eq({pfx, "_in_ready"},    {31'd0, in_ready}, 32'd1);
      check_eq({pfx, "_busy"},        {31'd0, busy}, 32'd0);
      check_eq({pfx, "_state"},       {30'd0, state}, {30'd0, S_IDLE});
   endtask

   // Safety net: the stimulus is fixed-length, this only guards a broken clock
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      // X: r1,r2->r9  Y: r9,r9->r10  Z: r10,r10->r11  I0..I3: r1,r2->r20..r23
      logic [31:0] chain [7];
      logic [31:0] bad [4];
      logic [13:0] iv_tab;
      logic [13:0] rdy_tab;
      int          widx;
      int          iidx;
      int          drops;
      int          issues;
      logic        acc;

      chain[0] = 32'h0009_1045;
      chain[1] = 32'h000A_4A45;
      chain[2] = 32'h000B_5285;
      chain[3] = 32'h0014_1045;
      chain[4] = 32'h0015_1045;
      chain[5] = 32'h0016_1045;
      chain[6] = 32'h0017_1045;
      bad[0]   = 32'h0003_1041;
      bad[1]   = 32'h0003_1049;
      bad[2]   = 32'h0003_104B;
      bad[3]   = 32'h0003_104E;

      // ---- reset ----
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset_values("rst");
`ifdef MP_ISSUE_STATS_EN
      check_eq("rst_stat_issued", {16'd0, stat_issued}, 32'd0);
      check_eq("rst_stat_stalls", {16'd0, stat_stalls}, 32'd0);
`endif

      // ---- single add into empty FIFO: issue two edges after the push ----
      in_valid = 1'b1;
      in_instr = 32'h0003_1045;
      step();
      in_valid = 1'b0;
      check_eq("t1_valid_after_push", {31'd0, issue_valid}, 32'd0);
      check_eq("t1_busy_buffered",    {31'd0, busy}, 32'd1);
      step();
      check_eq("t1_issue_valid", {31'd0, issue_valid}, 32'd1);
      check_eq("t1_issue_instr", issue_instr, 32'h0003_1045);
      step();
      check_eq("t1_valid_drops",  {31'd0, issue_valid}, 32'd0);
      check_eq("t1_instr_holds",  issue_instr, 32'h0003_1045);
      check_eq("t1_busy_window",  {31'd0, busy}, 32'd1);
      step();
      check_eq("t1_busy_clear",   {31'd0, busy}, 32'd0);
      check_eq("t1_state_idle",   {30'd0, state}, {30'd0, S_IDLE});

      // ---- RAW stall: add r3,r2->r4 right behind add r1,r2->r3 ----
`ifdef MP_ISSUE_STATS_EN
      base_a = stat_stalls;
      base_b = stat_issued;
`endif
      in_valid = 1'b1;
      in_instr = 32'h0003_1045;
      step();
      in_instr = 32'h0004_10C5;
      step();
      in_valid = 1'b0;
      check_eq("t2_first_valid", {31'd0, issue_valid}, 32'd1);
      check_eq("t2_first_instr", issue_instr, 32'h0003_1045);
      check_eq("t2_state_issue", {30'd0, state}, {30'd0, S_ISSUE});
      step();
      check_eq("t2_stall_valid", {31'd0, issue_valid}, 32'd0);
      check_eq("t2_state_stall", {30'd0, state}, {30'd0, S_STALL});
      step();
      check_eq("t2_stall2_valid", {31'd0, issue_valid}, 32'd0);
      check_eq("t2_state_resume", {30'd0, state}, {30'd0, S_ISSUE});
      step();
      check_eq("t2_second_valid", {31'd0, issue_valid}, 32'd1);
      check_eq("t2_second_instr", issue_instr, 32'h0004_10C5);
      check_eq("t2_state_idle",   {30'd0, state}, {30'd0, S_IDLE});
`ifdef MP_ISSUE_STATS_EN
      check_eq("t2_stat_stalls", {16'd0, 16'(stat_stalls - base_a)}, 32'd1);
      check_eq("t2_stat_issued", {16'd0, 16'(stat_issued - base_b)}, 32'd2);
`endif
      go_idle(3);
      check_eq("t2_busy_clear", {31'd0, busy}, 32'd0);

      // ---- invalid opcodes 1,9,11,14: four drops, no issue ----
`ifdef MP_ISSUE_STATS_EN
      base_a = stat_dropped;
`endif
      drops  = 0;
      issues = 0;
      for (int i = 0; i < 7; i++) begin
         in_valid = (i < 4);
         in_instr = bad[i % 4];
         step();
         drops  += int'(drop_pulse);
         issues += int'(issue_valid);
      end
      in_valid = 1'b0;
      check_eq("t3_drop_count",  drops, 32'd4);
      check_eq("t3_issue_count", issues, 32'd0);
      check_eq("t3_busy_clear",  {31'd0, busy}, 32'd0);
`ifdef MP_ISSUE_STATS_EN
      check_eq("t3_stat_dropped", {16'd0, 16'(stat_dropped - base_a)}, 32'd4);
`endif

      // ---- unary -a ignores addr2 even though r2 is in flight ----
      in_valid = 1'b1;
      in_instr = 32'h0002_0845;
      step();
      in_instr = 32'h0003_10C7;
      step();
      in_valid = 1'b0;
      check_eq("t4_writer_valid", {31'd0, issue_valid}, 32'd1);
      check_eq("t4_writer_instr", issue_instr, 32'h0002_0845);
      check_eq("t4_state_issue",  {30'd0, state}, {30'd0, S_ISSUE});
      step();
      check_eq("t4_unary_valid",  {31'd0, issue_valid}, 32'd1);
      check_eq("t4_unary_instr",  issue_instr, 32'h0003_10C7);
      go_idle(3);

      // ---- fill behind a stalled head, then drain with wrap ----
      // Hand-derived per-cycle table: issues at cycles 2,5,8..12;
      // in_ready low at cycles 6 and 7 while four entries are held.
      iv_tab  = 14'b01_1111_0010_0100;
      rdy_tab = 14'b11_1111_0011_1111;
      widx = 0;
      iidx = 0;
      for (int c = 0; c < 14; c++) begin
         if (widx < 7) begin
            in_valid = 1'b1;
            in_instr = chain[widx];
         end else begin
            in_valid = 1'b0;
         end
         check_eq($sformatf("t5_c%0d_in_ready", c), {31'd0, in_ready}, {31'd0, rdy_tab[c]});
         check_eq($sformatf("t5_c%0d_issue_valid", c), {31'd0, issue_valid}, {31'd0, iv_tab[c]});
         if (iv_tab[c] && iidx < 7) begin
            check_eq($sformatf("t5_c%0d_issue_instr", c), issue_instr, chain[iidx]);
            iidx++;
         end
         acc = in_valid && in_ready;
         step();
         if (acc) widx++;
      end
      check_eq("t5_all_accepted", widx, 32'd7);
      go_idle(3);
      check_eq("t5_busy_clear", {31'd0, busy}, 32'd0);

      // ---- flush with three buffered entries and a concurrent push ----
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_instr = chain[c];
         step();
      end
      check_eq("t6_pre_issue_valid", {31'd0, issue_valid}, 32'd1);
      check_eq("t6_pre_in_ready",    {31'd0, in_ready}, 32'd1);
      in_instr = chain[5];
      flush    = 1'b1;
      step();
      in_instr = chain[6];
      check_eq("t6_state_flush",   {30'd0, state}, {30'd0, S_FLUSH});
      check_eq("t6_in_ready_low",  {31'd0, in_ready}, 32'd0);
      check_eq("t6_no_issue",      {31'd0, issue_valid}, 32'd0);
      check_eq("t6_busy_flush",    {31'd0, busy}, 32'd1);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_eq("t6_state_flush2",  {30'd0, state}, {30'd0, S_FLUSH});
      check_eq("t6_in_ready_low2", {31'd0, in_ready}, 32'd0);
      check_eq("t6_no_issue2",     {31'd0, issue_valid}, 32'd0);
      step();
      check_eq("t6_state_idle",    {30'd0, state}, {30'd0, S_IDLE});
      check_eq("t6_in_ready_back", {31'd0, in_ready}, 32'd1);
      check_eq("t6_busy_clear",    {31'd0, busy}, 32'd0);
      issues = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         issues += int'(issue_valid);
      end
      check_eq("t6_nothing_issued", issues, 32'd0);

      // ---- asynchronous reset in the middle of an issue ----
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_instr = chain[c];
         step();
      end
      check_eq("t7_pre_issue_valid", {31'd0, issue_valid}, 32'd1);
      check_eq("t7_pre_busy",        {31'd0, busy}, 32'd1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("t7_async");
`ifdef MP_ISSUE_STATS_EN
      check_eq("t7_stat_issued", {16'd0, stat_issued}, 32'd0);
      check_eq("t7_stat_dropped", {16'd0, stat_dropped}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      issues = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         issues += int'(issue_valid);
      end
      check_eq("t7_fifo_lost", issues, 32'd0);
      check_eq("t7_busy_idle", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mp_issue_ctrl.md
Name: mp_issue_ctrl

Overview:
- Issue controller in front of the microprocessor datapath (instruction register -> register file -> ALU).
- Accepts 32-bit machine instructions from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Drops invalid opcodes and holds back any instruction whose source registers are still being written by an in-flight instruction (RAW hazard).
- Presents at most one instruction per cycle to the datapath's `instruction` input.

Parameters:
- FIFO_DEPTH, 4, instruction buffer entries; power of two, 2..16.
- HAZ_DEPTH, 2, cycles an issued destination register stays "in flight" for hazard checks; 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer offers in_instr
- in_instr  in  32  machine instruction: [5:0] opcode, [10:6] addr1, [15:11] addr2, [20:16] addr3 (dest)
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid && in_ready at posedge
- flush  in  1  discard all buffered instructions
- issue_valid  out  1  issue_instr is a new instruction this cycle
- issue_instr  out  32  instruction driven to the datapath
- drop_pulse  out  1  one-cycle pulse: an invalid opcode was discarded
- busy  out  1  FIFO non-empty or hazard window non-empty
- state  out  2  FSM state, for debug

Behaviour:
- Reset (async assert, sync release):
  - issue_valid=0, issue_instr=0, drop_pulse=0, in_ready=1, busy=0, state=IDLE.
  - FIFO empty; all hazard-window entries invalid.
- Valid opcodes: 2,3,4,5,6,7,8,10,12,13,15. Every other opcode is invalid.
- Unary opcodes (2 ~a, 7 -a, 13 |a|) read addr1 only. All other valid opcodes read addr1 and addr2.
- FIFO:
  - in_ready = !full.
  - Simultaneous push and pop when full is allowed only if the pop happens the same cycle (in_ready stays low when full; no combinational ready from pop).
  - Pointers wrap modulo FIFO_DEPTH; count is held in log2(FIFO_DEPTH)+1 bits.
- Head evaluation, every cycle the FIFO is non-empty:
  - Invalid opcode: pop; drop_pulse=1 next cycle; no issue; no hazard entry.
  - Valid opcode with a RAW hit: addr1, or addr2 for binary ops, equals any valid hazard-window dest. Result is stall: no pop, issue_valid=0.
  - Otherwise: pop; registered output issue_instr=head and issue_valid=1 on the next cycle; push addr3 into the hazard window.
- Hazard window:
  - HAZ_DEPTH-deep shift register of {valid, addr}; shifts every cycle.
  - Entry inserted with valid=1 on issue, otherwise valid=0.
  - An entry expires HAZ_DEPTH cycles after insertion.
- issue_instr holds its last value when issue_valid=0, so the datapath sees a stable instruction.
- Latency: an instruction pushed into an empty FIFO with no hazard has issue_valid high 2 cycles after the push edge (1 cycle FIFO write, 1 cycle output register).
- FSM:
  - IDLE: FIFO empty. -> ISSUE when FIFO non-empty.
  - ISSUE: head issued or dropped each cycle. -> STALL on RAW hit; -> IDLE when the last entry pops; -> FLUSH on flush.
  - STALL: no pop. -> ISSUE when the hit clears; -> FLUSH on flush.
  - FLUSH: FIFO emptied this cycle; in_ready=0; no issue. Stays until the hazard window is all invalid, then -> IDLE.
- flush:
  - Takes priority over push and pop in the same cycle; the pushed word is discarded.
  - flush while in FLUSH is ignored.
- Reset mid-operation: the FIFO, window and an in-progress issue are lost; outputs return to reset values immediately.
- busy = (count!=0) || any window valid || state==FLUSH.

Optional Feature:
- Macro: MP_ISSUE_STATS_EN.
- When defined, three 16-bit saturating output counters are added:
  - stat_issued: instructions issued.
  - stat_dropped: invalid opcodes dropped.
  - stat_stalls: cycles spent in STALL.
- The counters clear on rst and do not clear on flush.
- When undefined, the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then push 0x00031045 (add r1,r2->r3) into an empty FIFO -> issue_valid=1 with issue_instr=0x00031045 two cycles after the push; busy=0 HAZ_DEPTH cycles later.
- Push 0x00031045 then 0x000410C5 (add r3,r2->r4) back-to-back -> second instruction stalls exactly HAZ_DEPTH-1 cycles with state=STALL, then issues; stat_stalls=1 at default parameters.
- Push 0x00031041, 0x00031049, 0x0003104B, 0x0003104E (opcodes 1,9,11,14) -> four drop_pulse cycles, zero issue_valid, stat_dropped=4.
- Push 0x000310C7 (-a, addr1=3, addr2=2) right after a write to r2 -> no stall, because unary ops ignore addr2.
- Hold in_valid with distinct independent instructions and stall the head -> in_ready drops after FIFO_DEPTH accepts; releasing the stall drains FIFO_DEPTH issues in consecutive cycles with pointer wrap.
- Assert flush with 3 buffered entries plus one concurrent push -> no further issue, in_ready=0 until the window empties, state FLUSH->IDLE, count=0; assert rst mid-FIFO -> all outputs at reset values in the same cycle.
